// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S / left-justified audio DAC player.
package aud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        DELAY,
        SHIFT,
        PAD
    } aud_state_e;

    localparam int AUD_MODE_I2S = 0;
    localparam int AUD_MODE_LJ  = 1;

endpackage

// File: rtl/aud_player_i2s_if.sv
// Sample handshake between the audio source (master) and the DAC player (slave).
interface aud_player_i2s_if #(
    parameter int DATA_W = 16
);

    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data_l;
    logic [DATA_W-1:0] i_data_r;

    modport master (output i_valid, output i_data_l, output i_data_r, input o_ready);
    modport slave  (input i_valid, input i_data_l, input i_data_r, output o_ready);

endinterface

// File: rtl/aud_lrck_edge.sv
// Registers the DAC frame clock on the falling BCLK edge and flags its channel transitions.
module aud_lrck_edge (
    input  logic i_bclk,
    input  logic i_rst_n,
    input  logic i_lrck,
    output logic o_fall,
    output logic o_rise
);

    logic lrck_d_q;
    logic lrck_d_d;

    assign lrck_d_d = i_lrck;

    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d_q <= 1'b0;
        end else begin
            lrck_d_q <= lrck_d_d;
        end
    end

    assign o_fall = lrck_d_q & ~i_lrck;
    assign o_rise = ~lrck_d_q & i_lrck;

endmodule

// File: rtl/aud_player_i2s.sv
// Serial audio DAC player (I2S or left-justified) with a one-sample stereo holding register.
// Optional underrun counter port o_underrun_cnt is built when AUD_PLAYER_UNDERRUN_CNT_EN is defined.
module aud_player_i2s
    import aud_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LJ_MODE = 0
) (
    input  logic         i_bclk,
    input  logic         i_rst_n,
    input  logic         i_daclrck,
    input  logic         i_en,
    aud_player_i2s_if.slave s_if,
    output logic         o_aud_dacdat,
    output logic         o_underrun
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]  o_underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    aud_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              full_q, full_d;
    logic              dacdat_q, dacdat_d;
    logic              underrun_q, underrun_d;
    logic              fall;
    logic              rise;
    logic              chan_start;
    logic [DATA_W-1:0] word;
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    logic [15:0]       ucnt_q, ucnt_d;
`endif

    aud_lrck_edge u_lrck_edge (
        .i_bclk  (i_bclk),
        .i_rst_n (i_rst_n),
        .i_lrck  (i_daclrck),
        .o_fall  (fall),
        .o_rise  (rise)
    );

    // A fall starts a new stereo frame from the holding register; a rise replays the latched right word.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        right_d    = right_q;
        full_d     = full_q;
        dacdat_d   = 1'b0;
        underrun_d = 1'b0;
        chan_start = 1'b0;
        word       = '0;

        if (!i_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FRAME;
                end
                default: begin
                    if (fall) begin
                        chan_start = 1'b1;
                        if (full_q) begin
                            word    = hold_l_q;
                            right_d = hold_r_q;
                            full_d  = 1'b0;
                        end else begin
                            right_d    = '0;
                            underrun_d = 1'b1;
                        end
                    end else if (rise && state_q != WAIT_FRAME) begin
                        chan_start = 1'b1;
                        word       = right_q;
                    end else if (state_q == DELAY || (state_q == SHIFT && cnt_q != '0)) begin
                        dacdat_d = shift_q[DATA_W-1];
                        shift_d  = shift_q << 1;
                        cnt_d    = cnt_q - CNT_W'(1);
                        state_d  = SHIFT;
                    end else if (state_q == SHIFT) begin
                        state_d = PAD;
                    end
                end
            endcase
        end

        if (chan_start) begin
            if (LJ_MODE == AUD_MODE_LJ) begin
                dacdat_d = word[DATA_W-1];
                shift_d  = word << 1;
                cnt_d    = CNT_W'(DATA_W - 1);
                state_d  = SHIFT;
            end else begin
                shift_d = word;
                cnt_d   = CNT_W'(DATA_W);
                state_d = DELAY;
            end
        end

        // Accept is evaluated after transfer so a same-edge accept leaves the new sample held.
        if (s_if.i_valid && !full_q) begin
            hold_l_d = s_if.i_data_l;
            hold_r_d = s_if.i_data_r;
            full_d   = 1'b1;
        end
    end

`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_d && ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign o_underrun_cnt = ucnt_q;
`endif

    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            right_q    <= '0;
            full_q     <= 1'b0;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            right_q    <= right_d;
            full_q     <= full_d;
            dacdat_q   <= dacdat_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_if.o_ready = ~full_q;
    assign o_aud_dacdat = dacdat_q;
    assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_aud_player_i2s.sv
// Directed bench for aud_player_i2s: three DUT configurations share BCLK/LRCK, one enabled at a time.
module tb_aud_player_i2s;

    typedef struct {
        logic dac;
        logic und;
        int   k;
    } exp_t;

    logic        bclk = 1'b0;
    logic        rst_n;
    logic        lrck;
    logic        en0, en1, en2;
    logic        valid;
    logic [31:0] data_l, data_r;
    int          sel;
    int          checks = 0;
    int          errors = 0;
    string       tag = "init";
    exp_t        sb_q[$];

    logic dac0, dac1, dac2, und0, und1, und2;
    logic dac_sel, und_sel, ready_sel;
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    aud_player_i2s_if #(.DATA_W(16)) if0 ();
    aud_player_i2s_if #(.DATA_W(24)) if1 ();
    aud_player_i2s_if #(.DATA_W(32)) if2 ();

    assign if0.i_valid  = valid && (sel == 0);
    assign if0.i_data_l = data_l[15:0];
    assign if0.i_data_r = data_r[15:0];
    assign if1.i_valid  = valid && (sel == 1);
    assign if1.i_data_l = data_l[23:0];
    assign if1.i_data_r = data_r[23:0];
    assign if2.i_valid  = valid && (sel == 2);
    assign if2.i_data_l = data_l;
    assign if2.i_data_r = data_r;

    assign dac_sel   = (sel == 0) ? dac0 : (sel == 1) ? dac1 : dac2;
    assign und_sel   = (sel == 0) ? und0 : (sel == 1) ? und1 : und2;
    assign ready_sel = (sel == 0) ? if0.o_ready : (sel == 1) ? if1.o_ready : if2.o_ready;

    always #5 bclk = ~bclk;

    aud_player_i2s #(.DATA_W(16), .LJ_MODE(0)) dut0 (
        .i_bclk       (bclk),
        .i_rst_n      (rst_n),
        .i_daclrck    (lrck),
        .i_en         (en0),
        .s_if         (if0),
        .o_aud_dacdat (dac0),
        .o_underrun   (und0)
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (cnt0)
`endif
    );

    aud_player_i2s #(.DATA_W(24), .LJ_MODE(1)) dut1 (
        .i_bclk       (bclk),
        .i_rst_n      (rst_n),
        .i_daclrck    (lrck),
        .i_en         (en1),
        .s_if         (if1),
        .o_aud_dacdat (dac1),
        .o_underrun   (und1)
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (cnt1)
`endif
    );

    aud_player_i2s #(.DATA_W(32), .LJ_MODE(1)) dut2 (
        .i_bclk       (bclk),
        .i_rst_n      (rst_n),
        .i_daclrck    (lrck),
        .i_en         (en2),
        .s_if         (if2),
        .o_aud_dacdat (dac2),
        .o_underrun   (und2)
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (cnt2)
`endif
    );

    // Expected serial bit k edges after a channel edge for a word of the given width and framing.
    function automatic logic exp_bit(input logic [31:0] w, input int width, input int lj, input int k);
        if (lj != 0) begin
            if (k < width) return w[width-1-k];
        end else begin
            if (k >= 1 && k <= width) return w[width-k];
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", name, obs, exp);
        end
    endtask

`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
    task automatic check16(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask
`endif

    task automatic offer(input logic [31:0] l, input logic [31:0] r);
        data_l = l;
        data_r = r;
        valid  = 1'b1;
    endtask

    task automatic step(input logic lrck_v);
        exp_t e;
        logic rdy_pre;
        lrck    = lrck_v;
        rdy_pre = ready_sel;
        @(negedge bclk);
        #1;
        if (valid && rdy_pre) begin
            valid = 1'b0;
            check({tag, "_ready_after_accept"}, ready_sel, 1'b0);
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb_empty observed no expectation required one", tag);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("%s_dac_k%0d", tag, e.k), dac_sel, e.dac);
            check($sformatf("%s_und_k%0d", tag, e.k), und_sel, e.und);
        end
    endtask

    task automatic play(input logic lrck_v, input int n, input logic [31:0] w,
                        input int width, input int lj, input logic und_first);
        for (int k = 0; k < n; k++) begin
            sb_q.push_back('{dac: exp_bit(w, width, lj, k), und: (k == 0) ? und_first : 1'b0, k: k});
        end
        for (int k = 0; k < n; k++) begin
            step(lrck_v);
        end
    endtask

    task automatic idle(input logic lrck_v, input int n);
        play(lrck_v, n, 32'h0, 1, 1, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        en0    = 1'b0;
        en1    = 1'b0;
        en2    = 1'b0;
        lrck   = 1'b0;
        valid  = 1'b0;
        data_l = '0;
        data_r = '0;
        sel    = 0;

        #3;
        check("rst_ready0", if0.o_ready, 1'b1);
        check("rst_dac0", dac0, 1'b0);
        check("rst_und0", und0, 1'b0);
        check("rst_ready1", if1.o_ready, 1'b1);
        check("rst_dac1", dac1, 1'b0);
        check("rst_ready2", if2.o_ready, 1'b1);
        check("rst_dac2", dac2, 1'b0);
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        check16("rst_cnt0", cnt0, 16'h0000);
`endif
        #20;
        rst_n = 1'b1;

        // DUT0: 16-bit I2S, 32 BCLK per channel
        sel = 0;
        en0 = 1'b1;
        tag = "i2s_pre";
        offer(32'hA5F0, 32'h0F0F);
        idle(1'b1, 4);
        tag = "i2s_left";
        play(1'b0, 32, 32'hA5F0, 16, 0, 1'b0);
        check("ready_after_transfer", if0.o_ready, 1'b1);
        tag = "i2s_right";
        play(1'b1, 32, 32'h0F0F, 16, 0, 1'b0);

        tag = "underrun_left";
        play(1'b0, 32, 32'h0, 16, 0, 1'b1);
        tag = "underrun_right";
        offer(32'hC3A5, 32'h5A3C);
        play(1'b1, 32, 32'h0, 16, 0, 1'b0);
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        check16("underrun_cnt0", cnt0, 16'h0001);
`endif

        tag = "en_drop";
        play(1'b0, 6, 32'hC3A5, 16, 0, 1'b0);
        en0 = 1'b0;
        idle(1'b0, 4);
        en0 = 1'b1;
        tag = "reenable";
        idle(1'b0, 22);
        offer(32'h1234, 32'hFEDC);
        idle(1'b1, 32);
        tag = "resume_left";
        play(1'b0, 32, 32'h1234, 16, 0, 1'b0);
        tag = "resume_right";
        offer(32'h7777, 32'h8888);
        play(1'b1, 8, 32'hFEDC, 16, 0, 1'b0);
        check("full_before_reset", if0.o_ready, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dac0", dac0, 1'b0);
        check("midrst_und0", und0, 1'b0);
        check("midrst_ready0", if0.o_ready, 1'b1);
        en0 = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        check("postrst_ready0", if0.o_ready, 1'b1);
        check("postrst_dac0", dac0, 1'b0);
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        check16("postrst_cnt0", cnt0, 16'h0000);
`endif

        // DUT1: 24-bit left-justified
        sel = 1;
        en1 = 1'b1;
        tag = "lj_pre";
        offer(32'h800001, 32'h3C0F5A);
        idle(1'b1, 4);
        tag = "lj_left";
        play(1'b0, 32, 32'h800001, 24, 1, 1'b0);
        tag = "lj_right";
        play(1'b1, 32, 32'h3C0F5A, 24, 1, 1'b0);
        en1 = 1'b0;

        // DUT2: 32-bit left-justified with 16 BCLK per channel, so words are truncated
        sel = 2;
        en2 = 1'b1;
        tag = "trunc_pre";
        offer(32'hDEADBEEF, 32'h12345678);
        idle(1'b1, 4);
        tag = "trunc_left";
        play(1'b0, 16, 32'hDEADBEEF, 32, 1, 1'b0);
        tag = "trunc_right";
        play(1'b1, 16, 32'h12345678, 32, 1, 1'b0);
        tag = "trunc_underrun";
        play(1'b0, 16, 32'h0, 32, 1, 1'b1);
`ifdef AUD_PLAYER_UNDERRUN_CNT_EN
        check16("underrun_cnt2", cnt2, 16'h0001);
        check16("underrun_cnt1", cnt1, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aud_player_i2s.md
AUD_PLAYER_I2S -- requirements
Module: aud_player_i2s

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits (legal 16..32).
REQ-002 SHALL have parameter LJ_MODE, default 0; 0 = I2S (MSB one BCLK after LRCK edge), 1 = left-justified (MSB on LRCK edge).
REQ-003 SHALL have port i_bclk  input  1  serial bit clock; all state updates on its falling edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_daclrck  input  1  frame clock; 0 = left channel, 1 = right channel.
REQ-006 SHALL have port i_en  input  1  playback enable.
REQ-007 SHALL have port i_valid  input  1  stereo sample offered.
REQ-008 SHALL have port i_data_l  input  DATA_W  left sample, two's complement.
REQ-009 SHALL have port i_data_r  input  DATA_W  right sample, two's complement.
REQ-010 SHALL have port o_ready  output  1  holding register empty; sample accepted when i_valid & o_ready.
REQ-011 SHALL have port o_aud_dacdat  output  1  serial DAC data.
REQ-012 SHALL have port o_underrun  output  1  one-BCLK pulse when a left frame starts with no sample held.

Function
REQ-013 SHALL register i_daclrck each falling edge (lrck_d); fall = lrck_d & ~i_daclrck; rise = ~lrck_d & i_daclrck.
REQ-014 SHALL hold one stereo sample in a holding register; set full on accept, clear full on transfer to shifter; o_ready = ~full.
REQ-015 SHALL have states IDLE, WAIT_FRAME, DELAY, SHIFT, PAD.
REQ-016 SHALL go IDLE -> WAIT_FRAME when i_en = 1; go to IDLE from any state when i_en = 0, driving o_aud_dacdat = 0 from the next falling edge.
REQ-017 On fall in any non-IDLE state: SHALL load shifter with left/right pair from holding (clearing full), or zeros plus o_underrun = 1 if not full.
REQ-018 On rise in DELAY/SHIFT/PAD: SHALL load shifter with the right sample latched at the preceding fall; no holding access, no underrun.
REQ-019 After a channel edge: LJ_MODE = 1 -> drive MSB on that same falling edge, enter SHIFT; LJ_MODE = 0 -> drive 0, enter DELAY, drive MSB on the next falling edge.
REQ-020 SHIFT SHALL drive bits DATA_W-1 down to 0 on consecutive falling edges, then enter PAD driving 0 until the next channel edge.
REQ-021 A channel edge arriving before all DATA_W bits are sent SHALL truncate the current word and start the new channel per REQ-017/018.
REQ-022 WAIT_FRAME SHALL ignore rise; first transmission begins only at a fall.
REQ-023 Accept and transfer on the same edge SHALL leave full = 1 holding the new sample.
REQ-024 Bit counter SHALL be $clog2(DATA_W+1) bits and SHALL not wrap inside SHIFT.

Reset
REQ-025 While i_rst_n = 0: state = IDLE, o_aud_dacdat = 0, o_underrun = 0, full = 0 (o_ready = 1), lrck_d = 0, shifter and counter = 0.
REQ-026 Reset assertion mid-word SHALL abort the word immediately; the held sample is discarded.

Configuration
REQ-027 With AUD_PLAYER_UNDERRUN_CNT_EN defined: output o_underrun_cnt [15:0] SHALL count underruns, saturate at 16'hFFFF, reset to 0; without it the port and counter SHALL be absent.

Structure
REQ-028 Package aud_pkg SHALL hold the state enum type and LJ_MODE constants (AUD_MODE_I2S = 0, AUD_MODE_LJ = 1).
REQ-029 Sub-module aud_lrck_edge SHALL implement REQ-013 (registered LRCK, fall/rise outputs).

Verification
REQ-030 DATA_W=16, I2S, L=16'hA5F0, R=16'h0F0F, 32-BCLK frames -> left bits appear falling edges 1..16 after fall, right 1..16 after rise, zeros elsewhere.
REQ-031 LJ_MODE=1, DATA_W=24, L=24'h800001 -> MSB 1 on fall edge, 22 zeros, LSB 1 at edge 23.
REQ-032 i_valid held 0 at a fall -> o_underrun pulses one BCLK, both channels output all zeros; counter = 1 when macro defined.
REQ-033 DATA_W=32, LRCK half-period 16 BCLK -> only 16 MSBs sent per channel, then truncation at next edge.
REQ-034 i_en dropped mid-word -> o_aud_dacdat = 0 next edge; re-enable resumes at the next fall only.
REQ-035 i_rst_n pulsed low mid-frame with full = 1 -> all outputs per REQ-025, o_ready = 1 after release.
